// File: rtl/bp_nonsynth_stall_histogram.sv
// bp_nonsynth_stall_histogram: bins per-cycle stall reports into saturating epoch counters and streams snapshots out
module bp_nonsynth_stall_histogram #(
    parameter int num_reasons_p  = 20,
    parameter int reason_width_p = 5,
    parameter int count_width_p  = 32,
    parameter int epoch_cycles_p = 4096,
    localparam int num_bins_lp   = num_reasons_p + 2,
    localparam int bin_width_lp  = $clog2(num_bins_lp)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      freeze_i,
    input  logic                      instr_v_i,
    input  logic                      stall_v_i,
    input  logic [reason_width_p-1:0] stall_reason_i,
    input  logic                      flush_i,
    output logic                      dump_v_o,
    input  logic                      dump_ready_i,
    output logic [bin_width_lp-1:0]   dump_bin_o,
    output logic [count_width_p-1:0]  dump_count_o,
    output logic [15:0]               dump_epoch_o,
    output logic                      dump_last_o,
    output logic                      busy_o,
    output logic [15:0]               drop_cnt_o
);
    localparam int ecw_lp = $clog2(epoch_cycles_p + 1);

    typedef enum logic {IDLE, DUMP} state_e;

    state_e                     state_q, state_d;
    logic [count_width_p-1:0]   live_q [num_bins_lp];
    logic [count_width_p-1:0]   live_d [num_bins_lp];
    logic [count_width_p-1:0]   live_inc [num_bins_lp];
    logic [count_width_p-1:0]   shadow_q [num_bins_lp];
    logic [count_width_p-1:0]   shadow_d [num_bins_lp];
    logic [ecw_lp-1:0]          ecnt_q, ecnt_d, cnt_next;
    logic [15:0]                epoch_q, epoch_d, snap_q, snap_d, drop_q, drop_d;
    logic [bin_width_lp-1:0]    idx_q, idx_d, sel;
    logic                       count_en, epoch_end, last, load;

    // Classify this cycle, advance the live bins and decide whether the epoch ends
    always_comb begin
        count_en  = ~freeze_i;
        sel       = instr_v_i ? bin_width_lp'(num_reasons_p)
                  : (stall_v_i && int'(stall_reason_i) < num_reasons_p) ? bin_width_lp'(stall_reason_i)
                  : bin_width_lp'(num_reasons_p + 1);
        cnt_next  = ecnt_q + ecw_lp'(count_en);
        epoch_end = (count_en && cnt_next == ecw_lp'(epoch_cycles_p)) || (flush_i && cnt_next != '0);
        for (int i = 0; i < num_bins_lp; i++) begin
            live_inc[i] = (count_en && sel == bin_width_lp'(i) && live_q[i] != '1)
                        ? live_q[i] + count_width_p'(1) : live_q[i];
            live_d[i]   = epoch_end ? '0 : live_inc[i];
        end
        ecnt_d  = epoch_end ? '0 : cnt_next;
        epoch_d = epoch_q + 16'(epoch_end);
    end

    // Dump FSM: a new snapshot loads from IDLE or on the final handshake, otherwise an epoch end is dropped
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        snap_d   = snap_q;
        idx_d    = idx_q;
        drop_d   = drop_q;
        load     = 1'b0;
        last     = idx_q == bin_width_lp'(num_bins_lp - 1);
        if (state_q == IDLE) begin
            load    = epoch_end;
            state_d = epoch_end ? DUMP : IDLE;
        end else if (dump_ready_i && last) begin
            load    = epoch_end;
            state_d = epoch_end ? DUMP : IDLE;
            idx_d   = '0;
        end else begin
            idx_d  = dump_ready_i ? idx_q + bin_width_lp'(1) : idx_q;
            drop_d = (epoch_end && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        end
        if (load) begin
            shadow_d = live_inc;
            snap_d   = epoch_q;
            idx_d    = '0;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ecnt_q  <= '0;
            epoch_q <= '0;
            snap_q  <= '0;
            drop_q  <= '0;
            idx_q   <= '0;
            for (int i = 0; i < num_bins_lp; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ecnt_q   <= ecnt_d;
            epoch_q  <= epoch_d;
            snap_q   <= snap_d;
            drop_q   <= drop_d;
            idx_q    <= idx_d;
            live_q   <= live_d;
            shadow_q <= shadow_d;
        end
    end

    assign dump_v_o     = state_q == DUMP;
    assign busy_o       = dump_v_o;
    assign dump_bin_o   = idx_q;
    assign dump_count_o = dump_v_o ? shadow_q[idx_q] : '0;
    assign dump_epoch_o = snap_q;
    assign dump_last_o  = dump_v_o && last;
    assign drop_cnt_o   = drop_q;
endmodule
